// File: rtl/bnn_stream_loader.sv
// Byte-stream front-end: frames image/conv/fc packets and drives the BNN load interface.
// Optional saturating frame counters are enabled by defining LOADER_STATS_EN.
module bnn_stream_loader #(
  parameter int IMG_DIM  = 28,
  parameter int ADDR_W   = 11,
  parameter int FC_CHUNK = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              image_in_valid,
  input  logic              image_in_ready,
  output logic              image [0:IMG_DIM-1][0:IMG_DIM-1],
  output logic              kernel_in_valid,
  output logic [7:0]        kernel_offset,
  output logic [ADDR_W-1:0] kernel_addr,
  output logic [1:0]        kernel_layer,
  output logic              frame_err
`ifdef LOADER_STATS_EN
  ,
  output logic [15:0]       stat_img,
  output logic [15:0]       stat_ker,
  output logic [15:0]       stat_err
`endif
);

  localparam int NPIX      = IMG_DIM * IMG_DIM;
  localparam int IMG_BYTES = (NPIX + 7) / 8;
  localparam int SH_W      = IMG_BYTES * 8;
  localparam int PW        = $clog2(NPIX);

  typedef enum logic [2:0] {IDLE, PAYLOAD, DRAIN, ISSUE_IMG, ISSUE_KER} state_t;

  state_t              state_q, state_d;
  logic [6:0]          cnt_q, cnt_d;
  logic [1:0]          type_q, type_d;
  logic [SH_W-9:0]     sh_q, sh_d;
  logic [SH_W-1:0]     sh_shift;
  logic [NPIX-1:0]     img_q, img_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          off_q, off_d;
  logic [1:0]          layer_q, layer_d;
  logic                err_q, err_d;
  logic                commit_img, commit_ker;
  logic                accept, final_byte;
  logic [24:0]         ker_bits;
  logic [FC_CHUNK-1:0] fc_bits;

  function automatic logic [6:0] frame_len(input logic [1:0] t);
    case (t)
      2'd0:    frame_len = 7'(IMG_BYTES + 1);
      2'd1,
      2'd2:    frame_len = 7'd8;
      default: frame_len = 7'd7;
    endcase
  endfunction

  // The shift register keeps all but the newest byte; the newest is appended
  // combinationally so a commit can use the complete frame in the same cycle.
  assign sh_shift   = {sh_q, s_data};
  assign ker_bits   = sh_shift[31:7];
  assign fc_bits    = sh_shift[23 -: FC_CHUNK];
  assign accept     = s_valid && s_ready;
  assign final_byte = (cnt_q == frame_len(type_q) - 7'd1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    type_d     = type_q;
    sh_d       = sh_q;
    img_d      = img_q;
    addr_d     = addr_q;
    off_d      = off_q;
    layer_d    = layer_q;
    err_d      = 1'b0;
    commit_img = 1'b0;
    commit_ker = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d  = 7'd1;
          type_d = s_data[1:0];
          if (s_data[7:2] != '0) begin
            err_d   = 1'b1;
            state_d = s_last ? IDLE : DRAIN;
          end else if (s_last) begin
            err_d = 1'b1;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          sh_d  = sh_shift[SH_W-9:0];
          cnt_d = cnt_q + 7'd1;
          if (final_byte && s_last) begin
            if (type_q == 2'd0) begin
              commit_img = 1'b1;
              img_d      = sh_shift[SH_W-1 -: NPIX];
              state_d    = ISSUE_IMG;
            end else begin
              commit_ker = 1'b1;
              layer_d    = type_q;
              img_d      = '0;
              state_d    = ISSUE_KER;
              if (type_q == 2'd3) begin
                addr_d = sh_shift[32 +: ADDR_W];
                off_d  = sh_shift[31:24];
                for (int unsigned q = 0; q < FC_CHUNK; q++)
                  img_d[PW'(NPIX - 1 - q)] = fc_bits[5'(FC_CHUNK - 1 - q)];
              end else begin
                addr_d = sh_shift[40 +: ADDR_W];
                off_d  = sh_shift[39:32];
                for (int unsigned q = 0; q < 25; q++)
                  img_d[PW'(NPIX - 1 - ((q / 5) * IMG_DIM + (q % 5)))] = ker_bits[5'(24 - q)];
              end
            end
          end else if (s_last) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (final_byte) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept && s_last) state_d = IDLE;
      end
      ISSUE_IMG: begin
        if (image_in_ready) state_d = IDLE;
      end
      ISSUE_KER: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      type_q  <= '0;
      sh_q    <= '0;
      img_q   <= '0;
      addr_q  <= '0;
      off_q   <= '0;
      layer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      sh_q    <= sh_d;
      img_q   <= img_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      layer_q <= layer_d;
      err_q   <= err_d;
    end
  end

  assign s_ready         = (state_q == IDLE) || (state_q == PAYLOAD) || (state_q == DRAIN);
  assign image_in_valid  = (state_q == ISSUE_IMG);
  assign kernel_in_valid = (state_q == ISSUE_KER);
  assign kernel_addr     = addr_q;
  assign kernel_offset   = off_q;
  assign kernel_layer    = layer_q;
  assign frame_err       = err_q;

  for (genvar r = 0; r < IMG_DIM; r++) begin : g_row
    for (genvar c = 0; c < IMG_DIM; c++) begin : g_col
      assign image[r][c] = img_q[NPIX - 1 - (r * IMG_DIM + c)];
    end
  end

`ifdef LOADER_STATS_EN
  logic [15:0] st_img_q, st_ker_q, st_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_img_q <= '0;
      st_ker_q <= '0;
      st_err_q <= '0;
    end else begin
      if (commit_img && st_img_q != '1) st_img_q <= st_img_q + 16'd1;
      if (commit_ker && st_ker_q != '1) st_ker_q <= st_ker_q + 16'd1;
      if (err_d && st_err_q != '1)      st_err_q <= st_err_q + 16'd1;
    end
  end

  assign stat_img = st_img_q;
  assign stat_ker = st_ker_q;
  assign stat_err = st_err_q;
`endif

endmodule

// File: doc/bnn_stream_loader.md
Name: bnn_stream_loader

Overview:
- Upstream front-end of the BNN classifier top.
- Accepts a byte-wide valid/ready stream of framed packets: images and conv1/conv2/fc weight records.
- Assembles each packet and drives the classifier's load interface: image_in_valid/ready handshake, one-cycle kernel_in_valid writes, and the shared 28x28 image bus that carries both pixels and kernel bits.

Parameters:
- IMG_DIM, 28: image side length. IMG_BYTES = ceil(IMG_DIM*IMG_DIM/8) = 98.
- ADDR_W, 11: kernel_addr width.
- FC_CHUNK, 20: binary fc weight bits per write. Must be ≤ 24.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input byte valid.
- s_ready  out  1  input byte accepted when s_valid&s_ready.
- s_data  in  8  input byte.
- s_last  in  1  marks final byte of a frame.
- image_in_valid  out  1  assembled image available.
- image_in_ready  in  1  classifier accepts image.
- image  out  IMG_DIM x IMG_DIM  unpacked bit array [0:IMG_DIM-1][0:IMG_DIM-1]; shared pixel/kernel bus.
- kernel_in_valid  out  1  one-cycle weight write strobe.
- kernel_offset  out  8  offset byte for the write.
- kernel_addr  out  ADDR_W  write address.
- kernel_layer  out  2  1=conv1, 2=conv2, 3=fc.
- frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Reset: all outputs 0, image bus all 0, state IDLE. Reset mid-frame discards partial data; no write or image is issued.
- Header byte (first byte in IDLE):
  - type = s_data[1:0]: 0=image, 1=conv1, 2=conv2, 3=fc.
  - s_data[7:2] ≠ 0 → frame_err, go to DRAIN. If the header byte itself carries s_last, return to IDLE.
- Frame lengths, header included: image 1+IMG_BYTES (99); conv1/conv2 8; fc 7.
- Image payload:
  - Byte k, bit 7-b → flat pixel p = 8k+b, row-major: image[p/IMG_DIM][p%IMG_DIM].
  - Pad bits past IMG_DIM² are ignored.
- Kernel payload (conv1/conv2):
  - Bytes 1-2: address, big-endian; kernel_addr = low ADDR_W bits.
  - Byte 3: offset.
  - Bytes 4-7: 32 bits MSB-first. Bit q<25 → image[q/5][q%5]; bits 25-31 ignored.
- Fc payload:
  - Address and offset bytes as for conv.
  - Bytes 4-6: 24 bits MSB-first. Bits 0..FC_CHUNK-1 → image[0][0..FC_CHUNK-1].
- During kernel writes, all image bus bits outside the fields above drive 0.
- States: IDLE, PAYLOAD, DRAIN, ISSUE_IMG, ISSUE_KER. byte_cnt is 7 bits and counts accepted bytes within the frame.
- s_ready = 1 in IDLE, PAYLOAD and DRAIN; 0 in ISSUE_IMG and ISSUE_KER.
- Commit rule: a frame commits only when s_last arrives exactly on its final byte.
  - s_last early → frame_err, back to IDLE; nothing issued.
  - Final byte without s_last → frame_err, DRAIN. DRAIN discards bytes up to and including s_last, then returns to IDLE.
- Image commit:
  - Last byte accepted at cycle N → image_in_valid=1 from N+1 (ISSUE_IMG).
  - image bus is held stable until image_in_valid&image_in_ready, then image_in_valid drops and the state returns to IDLE.
  - Nothing else is issued while the image waits; back-pressure applies via s_ready=0.
- Kernel commit:
  - Last byte at cycle N → kernel_in_valid=1 for exactly cycle N+1 (ISSUE_KER), with kernel_addr/offset/layer/image stable.
  - The classifier is always ready. State returns to IDLE at N+2.
- Payload shift/assembly registers are internal. The image output register is updated only at commit, so a partially received frame never appears on the bus.
- frame_err is a single-cycle pulse per bad frame, not repeated while in DRAIN.

Optional Feature:
- LOADER_STATS_EN adds outputs stat_img, stat_ker and stat_err, each 16 bits.
  - They count committed images, committed kernel/fc writes, and frame_err pulses.
  - Counters saturate at 0xFFFF and reset to 0.
- Without the macro these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Image frame with header 0x00 and 98 bytes 0xAA, s_last on byte 99 → image_in_valid the next cycle; image[r][c] = ~c&1 per flat index (pixel 0=1, pixel 1=0); holds until image_in_ready, then clears; s_ready=0 throughout.
- conv2 frame 02,03,FF,7F,FF,FF,FF,80 with s_last → single kernel_in_valid pulse; kernel_layer=2, kernel_addr=0x3FF, kernel_offset=0x7F; image[0..4][0..4] all 1, all other bits 0.
- fc frame 03,00,09,12,F0,00,0F with s_last → kernel_layer=3, kernel_addr=9, kernel_offset=0x12, image[0][0:3]=1, image[0][4:19]=0.
- conv1 frame with s_last on byte 5 → frame_err pulse, no kernel_in_valid; next valid frame is processed normally.
- Header 0x84 followed by 3 bytes, s_last on the 3rd → one frame_err, bytes drained, IDLE after the s_last byte.
- rst_n pulled low at image byte 50, then a full frame sent → image_in_valid only after the new frame; no stale pixels on the bus.
